// File: rtl/t03_fetch_sequencer.sv
// rtl/t03_fetch_sequencer.sv - RV32I memory bus sequencer: instruction fetch vs load/store, PC freeze control
// Optional bus-ack timeout enabled by defining T03_BUS_TIMEOUT_EN.
module t03_fetch_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] fetch_addr,
  input  logic        ld_req,
  input  logic        st_req,
  input  logic [31:0] data_addr,
  input  logic [31:0] store_data,
  input  logic [3:0]  store_sel,
  input  logic        bus_ack,
  input  logic [31:0] bus_dat_i,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_adr,
  output logic [31:0] bus_dat_o,
  output logic [3:0]  bus_sel,
  output logic        freeze_pc,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        bus_err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_EXEC  = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_WB    = 3'd4;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_timeout_out_of_range
  end

  logic [2:0]  state_q, state_d;
  logic [31:0] bus_adr_q, bus_adr_d;
  logic [31:0] bus_dat_o_q, bus_dat_o_d;
  logic        bus_we_q, bus_we_d;
  logic [3:0]  bus_sel_q, bus_sel_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] load_data_q, load_data_d;
  logic        is_load_q, is_load_d;
  logic        bus_err_q, bus_err_d;
  logic        start_fetch;
`ifdef T03_BUS_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0]  wait_cnt_q, wait_cnt_d;
`endif

  always_comb begin
    state_d     = state_q;
    bus_adr_d   = bus_adr_q;
    bus_dat_o_d = bus_dat_o_q;
    bus_we_d    = bus_we_q;
    bus_sel_d   = bus_sel_q;
    instr_d     = instr_q;
    load_data_d = load_data_q;
    is_load_d   = is_load_q;
    bus_err_d   = bus_err_q;
    start_fetch = 1'b0;
`ifdef T03_BUS_TIMEOUT_EN
    wait_cnt_d  = wait_cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        state_d     = S_FETCH;
        start_fetch = 1'b1;
      end
      S_FETCH: begin
        if (bus_ack) begin
          instr_d = bus_dat_i;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (ld_req || st_req) begin
          // Simultaneous ld/st requests resolve to a store.
          state_d     = S_DATA;
          bus_adr_d   = data_addr;
          bus_dat_o_d = store_data;
          bus_we_d    = st_req;
          bus_sel_d   = st_req ? store_sel : 4'hF;
          is_load_d   = !st_req;
        end else begin
          state_d     = S_FETCH;
          start_fetch = 1'b1;
        end
      end
      S_DATA: begin
        if (bus_ack) begin
          if (is_load_q) begin
            load_data_d = bus_dat_i;
          end
          state_d = S_WB;
        end
      end
      S_WB: begin
        state_d     = S_FETCH;
        start_fetch = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

`ifdef T03_BUS_TIMEOUT_EN
    if ((state_q == S_FETCH || state_q == S_DATA) && !bus_ack) begin
      if (wait_cnt_q == TIMEOUT_LAST) begin
        bus_err_d   = 1'b1;
        state_d     = S_FETCH;
        start_fetch = 1'b1;
        if (state_q == S_FETCH) begin
          instr_d = NOP_INSTR;
        end else begin
          load_data_d = '0;
        end
      end else begin
        wait_cnt_d = wait_cnt_q + 8'd1;
      end
    end
    if (start_fetch || state_d == S_DATA) begin
      wait_cnt_d = '0;
    end
`endif

    if (start_fetch) begin
      bus_adr_d = fetch_addr;
      bus_we_d  = 1'b0;
      bus_sel_d = 4'hF;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      bus_adr_q   <= '0;
      bus_dat_o_q <= '0;
      bus_we_q    <= 1'b0;
      bus_sel_q   <= '0;
      instr_q     <= NOP_INSTR;
      load_data_q <= '0;
      is_load_q   <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus_adr_q   <= bus_adr_d;
      bus_dat_o_q <= bus_dat_o_d;
      bus_we_q    <= bus_we_d;
      bus_sel_q   <= bus_sel_d;
      instr_q     <= instr_d;
      load_data_q <= load_data_d;
      is_load_q   <= is_load_d;
      bus_err_q   <= bus_err_d;
    end
  end

`ifdef T03_BUS_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`endif

  assign bus_req     = (state_q == S_FETCH) || (state_q == S_DATA);
  assign bus_we      = bus_we_q;
  assign bus_adr     = bus_adr_q;
  assign bus_dat_o   = bus_dat_o_q;
  assign bus_sel     = bus_sel_q;
  // The PC only advances in a non-memory EXEC or in WB, once per instruction.
  assign freeze_pc   = !(((state_q == S_EXEC) && !ld_req && !st_req) || (state_q == S_WB));
  assign instr       = instr_q;
  assign instr_valid = (state_q == S_EXEC);
  assign load_data   = load_data_q;
  assign load_valid  = (state_q == S_WB) && is_load_q;
  assign bus_err     = bus_err_q;

endmodule

// File: tb/tb_t03_fetch_sequencer.sv
// tb/tb_t03_fetch_sequencer.sv - table-driven bench for t03_fetch_sequencer
module tb_t03_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fetch_addr;
  logic        ld_req, st_req;
  logic [31:0] data_addr, store_data;
  logic [3:0]  store_sel;
  logic        bus_ack;
  logic [31:0] bus_dat_i;
  logic        bus_req, bus_we;
  logic [31:0] bus_adr, bus_dat_o;
  logic [3:0]  bus_sel;
  logic        freeze_pc;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] load_data;
  logic        load_valid;
  logic        bus_err;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  t03_fetch_sequencer #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .fetch_addr(fetch_addr), .ld_req(ld_req), .st_req(st_req),
    .data_addr(data_addr), .store_data(store_data), .store_sel(store_sel),
    .bus_ack(bus_ack), .bus_dat_i(bus_dat_i), .bus_req(bus_req), .bus_we(bus_we),
    .bus_adr(bus_adr), .bus_dat_o(bus_dat_o), .bus_sel(bus_sel), .freeze_pc(freeze_pc),
    .instr(instr), .instr_valid(instr_valid), .load_data(load_data),
    .load_valid(load_valid), .bus_err(bus_err)
  );

  typedef struct {
    logic [31:0] faddr;
    logic [31:0] iword;
    int          fwait;
    logic        ld;
    logic        st;
    logic [31:0] daddr;
    logic [31:0] sdata;
    logic [3:0]  ssel;
    int          dwait;
    logic [31:0] rdata;
    logic        stray;
    logic        exp_we;
    logic [3:0]  exp_sel;
    logic        exp_lv;
    logic [31:0] exp_ld;
    int          exp_cycles;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_bus_req"}, bus_req, 0);
    chk({tag, "_bus_we"}, bus_we, 0);
    chk({tag, "_bus_adr"}, bus_adr, 0);
    chk({tag, "_bus_dat_o"}, bus_dat_o, 0);
    chk({tag, "_bus_sel"}, bus_sel, 0);
    chk({tag, "_freeze_pc"}, freeze_pc, 1);
    chk({tag, "_instr"}, instr, 32'h00000013);
    chk({tag, "_instr_valid"}, instr_valid, 0);
    chk({tag, "_load_data"}, load_data, 0);
    chk({tag, "_load_valid"}, load_valid, 0);
    chk({tag, "_bus_err"}, bus_err, 0);
  endtask

  // Entered at a negedge with the DUT in FETCH for v; leaves it in FETCH for next_faddr.
  task automatic run_vec(input vec_t v, input logic [31:0] next_faddr);
    int  cyc = 0;
    logic mem;
    mem = v.ld || v.st;
    for (int w = 0; w <= v.fwait; w++) begin
      chk("fetch_req", bus_req, 1);
      chk("fetch_adr", bus_adr, v.faddr);
      chk("fetch_we", bus_we, 0);
      chk("fetch_sel", bus_sel, 4'hF);
      chk("fetch_freeze", freeze_pc, 1);
      bus_ack   = (w == v.fwait);
      bus_dat_i = (w == v.fwait) ? v.iword : 32'hA5A5A5A5;
      @(negedge clk); cyc++;
    end
    chk("exec_valid", instr_valid, 1);
    chk("exec_instr", instr, v.iword);
    chk("exec_req", bus_req, 0);
    bus_ack    = v.stray;
    bus_dat_i  = 32'hFFFFFFFF;
    ld_req     = v.ld;
    st_req     = v.st;
    data_addr  = v.daddr;
    store_data = v.sdata;
    store_sel  = v.ssel;
    if (!mem) fetch_addr = next_faddr;
    #1;
    chk("exec_freeze", freeze_pc, mem);
    @(negedge clk); cyc++;
    ld_req = 1'b0;
    st_req = 1'b0;
    if (mem) begin
      for (int w = 0; w <= v.dwait; w++) begin
        chk("data_req", bus_req, 1);
        chk("data_adr", bus_adr, v.daddr);
        chk("data_we", bus_we, v.exp_we);
        chk("data_sel", bus_sel, v.exp_sel);
        if (v.st) chk("data_dat_o", bus_dat_o, v.sdata);
        chk("data_freeze", freeze_pc, 1);
        chk("data_lv", load_valid, 0);
        bus_ack   = (w == v.dwait);
        bus_dat_i = (w == v.dwait) ? v.rdata : 32'h5A5A5A5A;
        @(negedge clk); cyc++;
      end
      chk("wb_req", bus_req, 0);
      chk("wb_freeze", freeze_pc, 0);
      chk("wb_load_valid", load_valid, v.exp_lv);
      chk("wb_load_data", load_data, v.exp_ld);
      bus_ack    = v.stray;
      bus_dat_i  = 32'hFFFFFFFF;
      fetch_addr = next_faddr;
      @(negedge clk); cyc++;
    end
    bus_ack = 1'b0;
    chk("instr_cycles", cyc, v.exp_cycles);
  endtask

  initial begin
    vecs[0] = '{32'h0,  32'h00500093, 0, 1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 0, 32'h0,        1'b0, 1'b0, 4'hF, 1'b0, 32'h0,        2};
    vecs[1] = '{32'h4,  32'h10002103, 1, 1'b1, 1'b0, 32'h100, 32'h0,        4'h0, 3, 32'hDEADBEEF, 1'b0, 1'b0, 4'hF, 1'b1, 32'hDEADBEEF, 8};
    vecs[2] = '{32'h8,  32'h00112023, 0, 1'b0, 1'b1, 32'h200, 32'h1234,     4'h3, 0, 32'h55555555, 1'b0, 1'b1, 4'h3, 1'b0, 32'hDEADBEEF, 4};
    vecs[3] = '{32'hC,  32'h00112223, 0, 1'b1, 1'b1, 32'h204, 32'hCAFEF00D, 4'hC, 2, 32'h0BADF00D, 1'b1, 1'b1, 4'hC, 1'b0, 32'hDEADBEEF, 6};
    vecs[4] = '{32'h10, 32'h00000013, 3, 1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 0, 32'h0,        1'b1, 1'b0, 4'hF, 1'b0, 32'hDEADBEEF, 5};
    vecs[5] = '{32'h14, 32'h0000A083, 0, 1'b1, 1'b0, 32'h300, 32'hFFFF,     4'h0, 0, 32'h00000001, 1'b0, 1'b0, 4'hF, 1'b1, 32'h00000001, 4};

    rst        = 1'b0;
    fetch_addr = 32'h0;
    ld_req     = 1'b0;
    st_req     = 1'b0;
    data_addr  = 32'h0;
    store_data = 32'h0;
    store_sel  = 4'h0;
    bus_ack    = 1'b0;
    bus_dat_i  = 32'h0;
    repeat (3) @(negedge clk);
    chk_reset_values("rst");

    fetch_addr = vecs[0].faddr;
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i], (i < 5) ? vecs[i+1].faddr : 32'h18);
    end

    // No ack in FETCH: times out with the macro, waits forever without it.
    chk("post_vec_req", bus_req, 1);
    chk("post_vec_adr", bus_adr, 32'h18);
    fetch_addr = 32'h80;
    bus_ack = 1'b0;
`ifdef T03_BUS_TIMEOUT_EN
    repeat (3) @(negedge clk);
    chk("to_err_before", bus_err, 0);
    @(negedge clk);
    chk("to_err", bus_err, 1);
    chk("to_instr_nop", instr, 32'h00000013);
    chk("to_refetch_req", bus_req, 1);
    chk("to_refetch_adr", bus_adr, 32'h80);
    chk("to_refetch_sel", bus_sel, 4'hF);
`else
    repeat (6) @(negedge clk);
    chk("nto_err", bus_err, 0);
    chk("nto_req", bus_req, 1);
    chk("nto_adr", bus_adr, 32'h18);
    chk("nto_instr", instr, 32'h0000A083);
`endif

    // Reset while a load is waiting in DATA.
    bus_ack   = 1'b1;
    bus_dat_i = 32'h00002083;
    @(negedge clk);
    bus_ack   = 1'b0;
    ld_req    = 1'b1;
    data_addr = 32'h400;
    @(negedge clk);
    ld_req = 1'b0;
    chk("mid_data_req", bus_req, 1);
    chk("mid_data_adr", bus_adr, 32'h400);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk_reset_values("async_rst");
    fetch_addr = 32'h40;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("restart_req", bus_req, 1);
    chk("restart_adr", bus_adr, 32'h40);
    chk("restart_we", bus_we, 0);
    chk("restart_sel", bus_sel, 4'hF);
    bus_ack   = 1'b1;
    bus_dat_i = 32'h00100113;
    @(negedge clk);
    bus_ack = 1'b0;
    chk("restart_instr", instr, 32'h00100113);
    chk("restart_valid", instr_valid, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
